winner_epoch_ctrl: RTL and testbench

Sequencer for the output-layer winner-take-all readout of the SNN. For each presented sample it clears the network and its spike counters, then lets the network run for a programmed number of timesteps while counting spikes per output neuron. It then performs a sequential argmax scan and reports the winning class over a valid/ready handshake. It sits between the output neuron layer and the classification consumer (host interface or accuracy logger).

---
 rtl/winner_pkg.sv | 29 ++
 rtl/spike_counter_bank.sv | 57 +++++
 rtl/winner_epoch_ctrl.sv | 176 +++++++++++++++++
 tb/tb_winner_epoch_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/winner_pkg.sv
// ============================================================================
// Module   : winner_pkg
// Purpose  : Shared types and helpers for the winner-take-all epoch
//            sequencer: FSM state encoding and index-width computation.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package winner_pkg;

  // FSM state encoding, explicit 3-bit width.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_RUN    = 3'd2,
    S_SCAN   = 3'd3,
    S_REPORT = 3'd4
  } win_state_t;

  // Width of a node index; a single node still needs one bit so that the
  // index port never collapses to zero width.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage : winner_pkg

`default_nettype wire

// File: rtl/spike_counter_bank.sv
// ============================================================================
// Module   : spike_counter_bank
// Purpose  : NUM_NODES saturating spike counters with synchronous clear,
//            a shared increment enable and one indexed read port.
// Ports    : clk_i     - clock, rising edge
//            rst_i     - synchronous active-high reset (clears counters)
//            clr_i     - synchronous clear of all counters
//            inc_en_i  - when high, counter[i] += nodes_i[i]
//            nodes_i   - per-node spike vector
//            rd_idx_i  - read port index
//            rd_cnt_o  - count of node rd_idx_i (0 when out of range)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spike_counter_bank #(
  parameter int NUM_NODES = 10,
  parameter int CNT_W     = 16,
  parameter int IDX_W     = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clr_i,
  input  logic                 inc_en_i,
  input  logic [NUM_NODES-1:0] nodes_i,
  input  logic [IDX_W-1:0]     rd_idx_i,
  output logic [CNT_W-1:0]     rd_cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] cnt_q [NUM_NODES];

  for (genvar gi = 0; gi < NUM_NODES; gi++) begin : g_cnt
    always_ff @(posedge clk_i) begin
      if (rst_i || clr_i) begin
        cnt_q[gi] <= '0;
      end else if (inc_en_i && nodes_i[gi] && (cnt_q[gi] != CNT_MAX)) begin
        // Saturate rather than wrap so a very long window cannot make a
        // busy node look quiet.
        cnt_q[gi] <= cnt_q[gi] + CNT_W'(1);
      end
    end
  end

  always_comb begin
    rd_cnt_o = '0;
    for (int i = 0; i < NUM_NODES; i++) begin
      if (rd_idx_i == IDX_W'(i)) begin
        rd_cnt_o = cnt_q[i];
      end
    end
  end

endmodule : spike_counter_bank

`default_nettype wire

// File: rtl/winner_epoch_ctrl.sv
// ============================================================================
// Module   : winner_epoch_ctrl
// Purpose  : Per-sample sequencer for the output-layer winner-take-all
//            readout: clear network, run a programmed number of timesteps
//            while counting spikes, argmax-scan the counters, then present
//            the winner over a valid/ready handshake.
// Ports    : clk_i, rst_i   - clock / synchronous active-high reset
//            start_i        - begin epoch (IDLE only)
//            window_len_i   - timesteps per epoch (0 behaves as 1)
//            tick_i         - timestep strobe
//            nodes_i        - output-neuron spikes (sampled on tick in RUN)
//            net_rst_o      - one-cycle network clear pulse
//            net_en_o       - network step enable during RUN
//            busy_o         - high outside IDLE
//            win_valid_o    - result valid (REPORT)
//            win_ready_i    - consumer accepts result
//            win_idx_o      - winning node index
//            win_count_o    - winner spike count
//            tie_o          - another node matched a non-zero winner count
//            none_o         - no node spiked during the epoch
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module winner_epoch_ctrl
  import winner_pkg::*;
#(
  parameter  int NUM_NODES = 10,
  parameter  int CNT_W     = 16,
  parameter  int WIN_W     = 16,
  localparam int IDX_W     = idx_width(NUM_NODES)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [WIN_W-1:0]     window_len_i,
  input  logic                 tick_i,
  input  logic [NUM_NODES-1:0] nodes_i,
  output logic                 net_rst_o,
  output logic                 net_en_o,
  output logic                 busy_o,
  output logic                 win_valid_o,
  input  logic                 win_ready_i,
  output logic [IDX_W-1:0]     win_idx_o,
  output logic [CNT_W-1:0]     win_count_o,
  output logic                 tie_o,
  output logic                 none_o
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NODES - 1);

  win_state_t       state_q,    state_d;
  logic [WIN_W-1:0] win_len_q,  win_len_d;
  logic [WIN_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [IDX_W-1:0] scan_idx_q, scan_idx_d;
  logic [IDX_W-1:0] max_idx_q,  max_idx_d;
  logic [CNT_W-1:0] max_q,      max_d;
  logic             tie_q,      tie_d;

  logic [WIN_W-1:0] tick_next;
  logic [CNT_W-1:0] rd_cnt;
  logic             in_report;

  // Latched length is never 0 and the count stops when it reaches the
  // length, so the increment below can never wrap.
  assign tick_next = tick_cnt_q + WIN_W'(1);

  spike_counter_bank #(
    .NUM_NODES (NUM_NODES),
    .CNT_W     (CNT_W),
    .IDX_W     (IDX_W)
  ) u_bank (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (state_q == S_CLEAR),
    .inc_en_i ((state_q == S_RUN) && tick_i),
    .nodes_i  (nodes_i),
    .rd_idx_i (scan_idx_q),
    .rd_cnt_o (rd_cnt)
  );

  always_comb begin
    state_d    = state_q;
    win_len_d  = win_len_q;
    tick_cnt_d = tick_cnt_q;
    scan_idx_d = scan_idx_q;
    max_idx_d  = max_idx_q;
    max_d      = max_q;
    tie_d      = tie_q;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          win_len_d = (window_len_i == '0) ? WIN_W'(1) : window_len_i;
          state_d   = S_CLEAR;
        end
      end

      S_CLEAR: begin
        tick_cnt_d = '0;
        scan_idx_d = '0;
        max_idx_d  = '0;
        max_d      = '0;
        tie_d      = 1'b0;
        state_d    = S_RUN;
      end

      S_RUN: begin
        if (tick_i) begin
          tick_cnt_d = tick_next;
          if (tick_next == win_len_q) begin
            state_d = S_SCAN;
          end
        end
      end

      S_SCAN: begin
        // Strictly-greater replacement: the lowest index keeps a tie.
        if (rd_cnt > max_q) begin
          max_d     = rd_cnt;
          max_idx_d = scan_idx_q;
          tie_d     = 1'b0;
        end else if ((rd_cnt == max_q) && (max_q != '0)) begin
          tie_d = 1'b1;
        end
        if (scan_idx_q == LAST_IDX) begin
          state_d = S_REPORT;
        end else begin
          scan_idx_d = scan_idx_q + IDX_W'(1);
        end
      end

      S_REPORT: begin
        if (win_ready_i) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      win_len_q  <= '0;
      tick_cnt_q <= '0;
      scan_idx_q <= '0;
      max_idx_q  <= '0;
      max_q      <= '0;
      tie_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      win_len_q  <= win_len_d;
      tick_cnt_q <= tick_cnt_d;
      scan_idx_q <= scan_idx_d;
      max_idx_q  <= max_idx_d;
      max_q      <= max_d;
      tie_q      <= tie_d;
    end
  end

  // Result fields are forced low outside REPORT so IDLE presents all zeros.
  assign in_report   = (state_q == S_REPORT);
  assign net_rst_o   = (state_q == S_CLEAR);
  assign net_en_o    = (state_q == S_RUN);
  assign busy_o      = (state_q != S_IDLE);
  assign win_valid_o = in_report;
  assign win_idx_o   = in_report ? max_idx_q : '0;
  assign win_count_o = in_report ? max_q : '0;
  assign tie_o       = in_report & tie_q;
  assign none_o      = in_report & (max_q == '0);

endmodule : winner_epoch_ctrl

`default_nettype wire

// File: tb/tb_winner_epoch_ctrl.sv
// ============================================================================
// Module   : tb_winner_epoch_ctrl
// Purpose  : Directed self-checking bench for winner_epoch_ctrl
//            (NUM_NODES=4, CNT_W=8, WIN_W=16).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_winner_epoch_ctrl;

  localparam int NUM_NODES = 4;
  localparam int CNT_W     = 8;
  localparam int WIN_W     = 16;
  localparam int IDX_W     = 2;

  logic                 clk = 1'b0;
  logic                 rst_i;
  logic                 start_i;
  logic [WIN_W-1:0]     window_len_i;
  logic                 tick_i;
  logic [NUM_NODES-1:0] nodes_i;
  logic                 net_rst_o;
  logic                 net_en_o;
  logic                 busy_o;
  logic                 win_valid_o;
  logic                 win_ready_i;
  logic [IDX_W-1:0]     win_idx_o;
  logic [CNT_W-1:0]     win_count_o;
  logic                 tie_o;
  logic                 none_o;

  int checks   = 0;
  int failures = 0;
  int n;

  winner_epoch_ctrl #(
    .NUM_NODES (NUM_NODES),
    .CNT_W     (CNT_W),
    .WIN_W     (WIN_W)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .window_len_i (window_len_i),
    .tick_i       (tick_i),
    .nodes_i      (nodes_i),
    .net_rst_o    (net_rst_o),
    .net_en_o     (net_en_o),
    .busy_o       (busy_o),
    .win_valid_o  (win_valid_o),
    .win_ready_i  (win_ready_i),
    .win_idx_o    (win_idx_o),
    .win_count_o  (win_count_o),
    .tie_o        (tie_o),
    .none_o       (none_o)
  );

  always #5 clk = ~clk;

  // Advance one clock; outputs are observed 1 time unit after the edge and
  // new inputs are applied at that same point.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_ticks(input int cnt, input logic [NUM_NODES-1:0] nd);
    for (int i = 0; i < cnt; i++) begin
      tick_i  = 1'b1;
      nodes_i = nd;
      step();
    end
    tick_i  = 1'b0;
    nodes_i = '0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!win_valid_o && cyc < 2000) begin
      step();
      cyc++;
    end
    chk("valid_timeout", {31'd0, win_valid_o}, 32'd1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},  {31'd0, busy_o},      32'd0);
    chk({tag, "_valid"}, {31'd0, win_valid_o}, 32'd0);
    chk({tag, "_nrst"},  {31'd0, net_rst_o},   32'd0);
    chk({tag, "_nen"},   {31'd0, net_en_o},    32'd0);
    chk({tag, "_idx"},   {30'd0, win_idx_o},   32'd0);
    chk({tag, "_cnt"},   {24'd0, win_count_o}, 32'd0);
    chk({tag, "_tie"},   {31'd0, tie_o},       32'd0);
    chk({tag, "_none"},  {31'd0, none_o},      32'd0);
  endtask

  task automatic chk_result(input string tag, input int idx, input int cnt,
                            input int tie, input int none);
    chk({tag, "_idx"},  {30'd0, win_idx_o},   idx);
    chk({tag, "_cnt"},  {24'd0, win_count_o}, cnt);
    chk({tag, "_tie"},  {31'd0, tie_o},       tie);
    chk({tag, "_none"}, {31'd0, none_o},      none);
  endtask

  // Handshake then confirm the block returns to IDLE the next cycle.
  task automatic handshake(input string tag);
    win_ready_i = 1'b1;
    step();
    win_ready_i = 1'b0;
    chk({tag, "_hs_valid"}, {31'd0, win_valid_o}, 32'd0);
    chk({tag, "_hs_busy"},  {31'd0, busy_o},      32'd0);
  endtask

  task automatic start_epoch(input int len);
    start_i      = 1'b1;
    window_len_i = WIN_W'(len);
    step();
    start_i = 1'b0;
  endtask

  initial begin
    rst_i        = 1'b1;
    start_i      = 1'b0;
    window_len_i = '0;
    tick_i       = 1'b0;
    nodes_i      = '0;
    win_ready_i  = 1'b0;
    step();
    step();
    chk_all_zero("reset");
    rst_i = 1'b0;
    step();
    chk_all_zero("idle");

    // Basic: node 2 fires every tick, node 0 once.
    start_epoch(3);
    chk("basic_nrst", {31'd0, net_rst_o}, 32'd1);
    chk("basic_busy", {31'd0, busy_o},    32'd1);
    chk("basic_nen0", {31'd0, net_en_o},  32'd0);
    step();
    chk("basic_nrst_off", {31'd0, net_rst_o}, 32'd0);
    chk("basic_nen1",     {31'd0, net_en_o},  32'd1);
    tick_i = 1'b1; nodes_i = 4'b0101; step();
    tick_i = 1'b1; nodes_i = 4'b0100; step();
    tick_i = 1'b1; nodes_i = 4'b0100; step();
    tick_i = 1'b0; nodes_i = '0;
    chk("basic_nen_scan", {31'd0, net_en_o}, 32'd0);
    // 2 (clear) + 3 ticks already elapsed; 4 scan cycles remain.
    wait_valid(n);
    chk("basic_latency", n, 4);
    chk_result("basic", 2, 3, 0, 0);
    handshake("basic");

    // Tie: nodes 1 and 3 fire every tick; lowest index wins.
    start_epoch(3);
    step();
    do_ticks(3, 4'b1010);
    wait_valid(n);
    chk("tie_latency", n, 4);
    chk_result("tie", 1, 3, 1, 0);
    handshake("tie");

    // Silence with window 0 (behaves as a single tick).
    start_epoch(0);
    step();
    do_ticks(1, 4'b0000);
    wait_valid(n);
    chk("silence_latency", n, 4);
    chk_result("silence", 0, 0, 0, 1);
    handshake("silence");

    // Saturation: 300 ticks on node 0 pin the 8-bit counter at 255.
    start_epoch(300);
    step();
    do_ticks(300, 4'b0001);
    wait_valid(n);
    chk("sat_latency", n, 4);
    chk_result("sat", 0, 255, 0, 0);

    // Backpressure: hold ready low, poke ignored inputs, data must not move.
    start_i = 1'b1; tick_i = 1'b1; nodes_i = 4'b1111; window_len_i = 16'd7;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_valid", {31'd0, win_valid_o}, 32'd1);
      chk("bp_nen",   {31'd0, net_en_o},    32'd0);
      chk_result("bp", 0, 255, 0, 0);
    end
    start_i = 1'b0; tick_i = 1'b0; nodes_i = '0;
    handshake("bp");
    step();
    chk("bp_stay_idle", {31'd0, busy_o}, 32'd0);

    // Reset in RUN after two ticks discards the epoch.
    start_epoch(5);
    step();
    do_ticks(2, 4'b1111);
    chk("mid_nen", {31'd0, net_en_o}, 32'd1);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    chk_all_zero("midrst");

    // Fresh epoch: only node 3 fires once; counts must start from zero.
    start_epoch(1);
    step();
    do_ticks(1, 4'b1000);
    wait_valid(n);
    chk("post_latency", n, 4);
    chk_result("post", 3, 1, 0, 0);
    handshake("post");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time guard so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule : tb_winner_epoch_ctrl

`default_nettype wire
